timer_counter: RTL and testbench

//  Memory-mapped countdown timer on the system bridge; its irq output drives one

---
 rtl/tc_pkg.sv | 32 +++
 rtl/timer_counter_if.sv | 13 +
 rtl/timer_counter.sv | 120 ++++++++++++
 tb/tb_timer_counter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared encodings for the memory-mapped countdown timer
package tc_pkg;

    // Timer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Register word offsets (byte address bits [3:2])
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE field encodings
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Only the exact reload encoding auto-reloads; every other value is one-shot
    function automatic logic is_reload(input logic [1:0] mode);
        return (mode == MODE_RELOAD) && (mode != MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - word-addressed register bus plus interrupt line of the timer
interface timer_counter_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output addr, output we, output din, input dout, input irq);
    modport slave  (input addr, input we, input din, output dout, output irq);

endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - countdown timer with one-shot/auto-reload irq (TIMER_COUNTER_MODE1_EN enables reload)
module timer_counter
    import tc_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    timer_counter_if.slave bus
);

    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        irq_flag_q;
    logic        irq_flag_d;
    logic        en_clr;
    logic        reload_mode;
    tc_state_e   state_q;
    tc_state_e   state_d;

    logic        ctrl_wr;
    logic        preset_wr;

    assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
    assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

`ifdef TIMER_COUNTER_MODE1_EN
    assign reload_mode = is_reload(ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]);
`else
    // MODE is still stored and read back, but never changes behaviour
    assign reload_mode = 1'b0;
`endif

    // Sequencer state, count and interrupt flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Next state: load, count down to 1, then raise the flag on the final step
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        en_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // A preset of 0 lands here too, so it expires like a preset of 1
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                if (reload_mode) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_clr = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Software-visible registers; a bus write to CTRL overrides the expiry EN clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= 4'd0;
            preset_q <= RESET_PRESET;
        end else begin
            if (ctrl_wr) begin
                ctrl_q <= bus.din[3:0];
            end else if (en_clr) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (preset_wr) begin
                preset_q <= bus.din;
            end
        end
    end

    // Read data mux; reserved offset reads zero
    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   bus.dout = {28'd0, ctrl_q};
            ADDR_PRESET: bus.dout = preset_q;
            ADDR_COUNT:  bus.dout = count_q;
            default:     bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed vector bench for timer_counter
module tb_timer_counter;
    import tc_pkg::*;

    localparam logic [31:0] RP = 32'h0000_0ABC;
`ifdef TIMER_COUNTER_MODE1_EN
    localparam bit MODE1 = 1'b1;
`else
    localparam bit MODE1 = 1'b0;
`endif

    localparam logic [31:0] C_EN_IM  = 32'h9;
    localparam logic [31:0] C_IM     = 32'h8;
    localparam logic [31:0] C_EN     = 32'h1;
    localparam logic [31:0] C_RELOAD = {28'd0, 1'b1, MODE_RELOAD, 1'b1};

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   pulses;
    vec_t vecs[14];

    timer_counter_if bus();

    timer_counter #(.RESET_PRESET(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [1:0] addr, input logic [31:0] din,
                                input logic [31:0] exp_dout, input logic exp_irq);
        vec_t v;
        v.we = we; v.addr = addr; v.din = din; v.exp_dout = exp_dout; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] din);
        bus.we   = we;
        bus.addr = addr;
        bus.din  = din;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        bus.we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.addr = 2'd0;
        bus.we   = 1'b0;
        bus.din  = 32'd0;

        vecs[0]  = mk(1'b0, ADDR_CTRL,   32'd0,   32'd0,   1'b0);
        vecs[1]  = mk(1'b0, ADDR_PRESET, 32'd0,   RP,      1'b0);
        vecs[2]  = mk(1'b0, ADDR_COUNT,  32'd0,   32'd0,   1'b0);
        vecs[3]  = mk(1'b0, 2'd3,        32'd0,   32'd0,   1'b0);
        vecs[4]  = mk(1'b1, ADDR_PRESET, 32'd5,   32'd5,   1'b0);
        vecs[5]  = mk(1'b1, ADDR_CTRL,   C_EN_IM | 32'hFFFF_FFF0, C_EN_IM, 1'b0);
        vecs[6]  = mk(1'b0, ADDR_COUNT,  32'd0,   32'd0,   1'b0);
        vecs[7]  = mk(1'b0, ADDR_COUNT,  32'd0,   32'd5,   1'b0);
        vecs[8]  = mk(1'b0, ADDR_COUNT,  32'd0,   32'd4,   1'b0);
        vecs[9]  = mk(1'b0, ADDR_COUNT,  32'd0,   32'd3,   1'b0);
        vecs[10] = mk(1'b0, ADDR_COUNT,  32'd0,   32'd2,   1'b0);
        vecs[11] = mk(1'b0, ADDR_COUNT,  32'd0,   32'd1,   1'b0);
        vecs[12] = mk(1'b0, ADDR_COUNT,  32'd0,   32'd0,   1'b1);
        vecs[13] = mk(1'b0, ADDR_CTRL,   32'd0,   C_IM,    1'b1);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset irq", {31'd0, bus.irq}, 32'd0);

        // Reset readback and one-shot expiry at edge 7 with PRESET=5
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].we, vecs[i].addr, vecs[i].din);
            chk($sformatf("vec%0d dout", i), bus.dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
        end

        // One-shot irq stays high until CTRL is rewritten with EN
        for (int i = 0; i < 20; i++) begin
            step(1'b0, ADDR_CTRL, 32'd0);
            chk($sformatf("hold%0d irq", i), {31'd0, bus.irq}, 32'd1);
        end
        step(1'b1, ADDR_CTRL, C_EN_IM);
        chk("rewrite irq same edge", {31'd0, bus.irq}, 32'd1);
        step(1'b0, ADDR_CTRL, 32'd0);
        chk("rewrite irq next edge", {31'd0, bus.irq}, 32'd0);
        step(1'b1, ADDR_CTRL, 32'd0);

        // MODE=01: periodic pulses every 6 cycles when reload is built in
        do_reset();
        step(1'b1, ADDR_PRESET, 32'd3);
        step(1'b1, ADDR_CTRL, C_RELOAD);
        pulses = 0;
        for (int e = 1; e <= 24; e++) begin
            step(1'b0, ADDR_COUNT, 32'd0);
            chk($sformatf("mode1 e%0d irq", e), {31'd0, bus.irq},
                {31'd0, MODE1 ? (e >= 5 && ((e - 5) % 6) == 0) : (e >= 5)});
            if (bus.irq) pulses++;
        end
        chk("mode1 pulse count", pulses, MODE1 ? 32'd4 : 32'd20);
        step(1'b0, ADDR_CTRL, 32'd0);
        chk("mode1 ctrl", bus.dout, MODE1 ? C_RELOAD : (C_RELOAD & 32'hE));

        // PRESET=0 expires like PRESET=1; bus write to CTRL beats the INT EN clear
        do_reset();
        step(1'b1, ADDR_PRESET, 32'd0);
        step(1'b1, ADDR_CTRL, C_EN_IM);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("p0 e1 irq", {31'd0, bus.irq}, 32'd0);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("p0 e2 irq", {31'd0, bus.irq}, 32'd0);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("p0 e3 irq", {31'd0, bus.irq}, 32'd1);
        chk("p0 e3 count", bus.dout, 32'd0);
        step(1'b1, ADDR_CTRL, C_EN_IM);
        chk("collide ctrl", bus.dout, C_EN_IM);
        chk("collide irq", {31'd0, bus.irq}, 32'd1);
        step(1'b0, ADDR_CTRL, 32'd0);
        chk("collide clear irq", {31'd0, bus.irq}, 32'd0);

        // Disable mid-count freezes COUNT; re-enable reloads; PRESET write defers
        do_reset();
        step(1'b1, ADDR_PRESET, 32'd10);
        step(1'b1, ADDR_CTRL, C_EN);
        step(1'b0, ADDR_COUNT, 32'd0);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("frz e2 count", bus.dout, 32'd10);
        step(1'b0, ADDR_COUNT, 32'd0);
        step(1'b1, ADDR_CTRL, 32'd0);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("frz e5 count", bus.dout, 32'd8);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, ADDR_COUNT, 32'd0);
            chk($sformatf("frz hold%0d", i), bus.dout, 32'd8);
        end
        step(1'b1, ADDR_CTRL, C_EN);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("reen load edge count", bus.dout, 32'd8);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("reen reload count", bus.dout, 32'd10);
        step(1'b1, ADDR_PRESET, 32'd2);
        chk("preset mid-count", bus.dout, 32'd2);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("count ignores preset", bus.dout, 32'd8);

        // Reset mid-count, COUNT write dropped, masked expiry keeps the flag
        do_reset();
        step(1'b1, ADDR_PRESET, 32'd10);
        step(1'b1, ADDR_CTRL, C_EN_IM);
        for (int i = 0; i < 5; i++) step(1'b0, ADDR_COUNT, 32'd0);
        chk("pre-reset count", bus.dout, 32'd7);
        reset = 1'b1;
        step(1'b0, ADDR_COUNT, 32'd0);
        reset = 1'b0;
        chk("mid reset count", bus.dout, 32'd0);
        chk("mid reset irq", {31'd0, bus.irq}, 32'd0);
        step(1'b0, ADDR_CTRL, 32'd0);
        chk("mid reset ctrl", bus.dout, 32'd0);
        step(1'b0, ADDR_PRESET, 32'd0);
        chk("mid reset preset", bus.dout, RP);
        step(1'b1, ADDR_COUNT, 32'h55);
        chk("count write dropped", bus.dout, 32'd0);
        step(1'b0, ADDR_COUNT, 32'd0);
        chk("idle count", bus.dout, 32'd0);
        step(1'b1, ADDR_PRESET, 32'd2);
        step(1'b1, ADDR_CTRL, C_EN);
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, ADDR_COUNT, 32'd0);
            chk($sformatf("masked e%0d irq", e), {31'd0, bus.irq}, 32'd0);
        end
        step(1'b0, ADDR_CTRL, 32'd0);
        chk("masked ctrl en cleared", bus.dout, 32'd0);
        step(1'b1, ADDR_CTRL, C_IM);
        chk("unmask irq", {31'd0, bus.irq}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
